// File: rtl/stream_crop_window.sv
// Crops a raster-order valid/ready pixel stream to a window that is latched on every s_sof,
// and regenerates sof/eol/eof for the cropped image through one output register stage.
module stream_crop_window #(
  parameter int COLS = 512,
  parameter int ROWS = 512,
  parameter int CH   = 1,
  parameter int DW   = 8,
  parameter int XW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XW-1:0]   cfg_x1,
  input  logic [XW-1:0]   cfg_y1,
  input  logic [XW-1:0]   cfg_x2,
  input  logic [XW-1:0]   cfg_y2,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [CH*DW-1:0] s_data,
  input  logic            s_sof,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [CH*DW-1:0] m_data,
  output logic            m_sof,
  output logic            m_eol,
  output logic            m_eof,
  output logic            frame_done,
  output logic            cfg_err,
  output logic            sync_err
);

  // state  | meaning
  // IDLE   | no frame open; beats without s_sof are dropped
  // ACTIVE | inside a frame; x_q/y_q hold the position of the next beat

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);
  localparam logic [XW-1:0] LAST_Y = XW'(ROWS - 1);
  // One extra bit so a geometry equal to 2^XW still compares correctly.
  localparam logic [XW:0]   COLS_W = (XW + 1)'(COLS);
  localparam logic [XW:0]   ROWS_W = (XW + 1)'(ROWS);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, y_q, x_d, y_d;
  logic [XW-1:0] x1_q, y1_q, x2_q, y2_q;
  logic          ok_q;

  logic          beat;
  logic          sof_beat;
  logic          cfg_ok;
  logic          take;
  logic          frame_end;
  logic          resync;
  logic          pass;
  logic [XW-1:0] cur_x, cur_y;
  logic [XW-1:0] wx1, wy1, wx2, wy2;
  logic          win_ok;

  assign s_ready  = !m_valid || m_ready;
  assign beat     = s_valid && s_ready;
  assign sof_beat = beat && s_sof;

  assign cfg_ok = (cfg_x1 <= cfg_x2) && (cfg_y1 <= cfg_y2) &&
                  ({1'b0, cfg_x2} < COLS_W) && ({1'b0, cfg_y2} < ROWS_W);

  // The sof beat itself is judged against the incoming cfg, not the stale latch.
  always_comb begin
    cur_x  = x_q;
    cur_y  = y_q;
    wx1    = x1_q;
    wy1    = y1_q;
    wx2    = x2_q;
    wy2    = y2_q;
    win_ok = ok_q;
    resync = 1'b0;
    if (sof_beat) begin
      cur_x  = '0;
      cur_y  = '0;
      wx1    = cfg_x1;
      wy1    = cfg_y1;
      wx2    = cfg_x2;
      wy2    = cfg_y2;
      win_ok = cfg_ok;
      resync = (state_q == ACTIVE);
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    take      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE:    take = sof_beat;
      ACTIVE:  take = beat;
      default: take = 1'b0;
    endcase
    if (take) begin
      frame_end = (cur_x == LAST_X) && (cur_y == LAST_Y);
      if (frame_end) begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end else if (cur_x == LAST_X) begin
        x_d     = '0;
        y_d     = cur_y + 1'b1;
        state_d = ACTIVE;
      end else begin
        x_d     = cur_x + 1'b1;
        y_d     = cur_y;
        state_d = ACTIVE;
      end
    end
  end

  assign pass = take && win_ok &&
                (cur_x >= wx1) && (cur_x <= wx2) &&
                (cur_y >= wy1) && (cur_y <= wy2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      ok_q       <= 1'b0;
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      sync_err   <= resync;
      if (sof_beat) begin
        x1_q    <= cfg_x1;
        y1_q    <= cfg_y1;
        x2_q    <= cfg_x2;
        y2_q    <= cfg_y2;
        ok_q    <= cfg_ok;
        cfg_err <= !cfg_ok;
      end
    end
  end

  // A beat only happens when s_ready is high, so loading never overwrites a stalled pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (pass) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_sof   <= (cur_x == wx1) && (cur_y == wy1);
      m_eol   <= (cur_x == wx2);
      m_eof   <= (cur_x == wx2) && (cur_y == wy2);
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_crop_window.sv
// Randomized bench for stream_crop_window: every frame's expected output is the raster scan of
// the window rectangle over the pixels actually sent, compared against the DUT output stream.
module tb_stream_crop_window;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int XW   = 4;
  localparam int PW   = CH * DW;
  localparam int NPIX = COLS * ROWS;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XW-1:0] cfg_x1 = '0, cfg_y1 = '0, cfg_x2 = '0, cfg_y2 = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [PW-1:0] m_data;
  logic          m_sof, m_eol, m_eof;
  logic          frame_done, cfg_err, sync_err;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  bit   rand_ready = 1'b0;
  bit   gaps = 1'b0;
  bit   mon_en = 1'b0;
  out_t exp_q[$];

  stream_crop_window #(.COLS(COLS), .ROWS(ROWS), .CH(CH), .DW(DW), .XW(XW)) dut (
    .clk(clk), .rst(rst),
    .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_x2(cfg_x2), .cfg_y2(cfg_y2),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .frame_done(frame_done), .cfg_err(cfg_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_out=%0d", n_out);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshake rule, stall stability and scoreboard comparison.
  initial begin
    logic        stall_q;
    logic [31:0] held;
    out_t        e;
    stall_q = 1'b0;
    held    = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        check_val("s_ready_rule", 32'(s_ready), 32'(!(m_valid && !m_ready)));
        if (stall_q)
          check_val("stall_hold", {m_valid, m_sof, m_eol, m_eof, 4'b0, m_data}, held);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check_val("spurious_out", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_val("m_data", 32'(m_data), 32'(e.d));
            check_val("m_flags", 32'({m_sof, m_eol, m_eof}), 32'({e.sof, e.eol, e.eof}));
          end
          n_out++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
        stall_q = m_valid && !m_ready;
        held    = {m_valid, m_sof, m_eol, m_eof, 4'b0, m_data};
      end
    end
  end

  task automatic drive_beat(input logic [PW-1:0] d, input logic sof);
    int budget;
    bit ok;
    budget = 200;
    ok     = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = s_ready;
      budget--;
      @(posedge clk);
      #1;
    end
    if (!ok) check_val("beat_timeout", 32'(budget), 32'd1);
    s_sof = 1'b0;
  endtask

  // Sends the first npix pixels of a frame; expectations are the window rectangle clipped to them.
  task automatic drive_frame(input int x1, input int y1, input int x2, input int y2,
                             input int npix, input bit expect_sync);
    logic [PW-1:0] pix[NPIX];
    bit            valid;
    out_t          e;
    int            idx;
    valid = (x1 <= x2) && (y1 <= y2) && (x2 < COLS) && (y2 < ROWS);
    for (int i = 0; i < NPIX; i++)
      pix[i] = {8'($urandom), 8'($urandom), 8'(i)};
    if (valid) begin
      for (int r = y1; r <= y2; r++) begin
        for (int c = x1; c <= x2; c++) begin
          idx = r * COLS + c;
          if (idx < npix) begin
            e.d   = pix[idx];
            e.sof = (r == y1) && (c == x1);
            e.eol = (c == x2);
            e.eof = (r == y2) && (c == x2);
            exp_q.push_back(e);
          end
        end
      end
    end
    cfg_x1 = XW'(x1);
    cfg_y1 = XW'(y1);
    cfg_x2 = XW'(x2);
    cfg_y2 = XW'(y2);
    for (int i = 0; i < npix; i++) begin
      drive_beat(pix[i], i == 0);
      if (i == 0) begin
        check_val("cfg_err", 32'(cfg_err), 32'(!valid));
        check_val("sync_err", 32'(sync_err), 32'(expect_sync));
        check_val("frame_done_early", 32'(frame_done), 32'd0);
        // Scramble the inputs: the latched window must stay in force for the rest of the frame.
        cfg_x1 = XW'($urandom);
        cfg_y1 = XW'($urandom);
        cfg_x2 = XW'($urandom);
        cfg_y2 = XW'($urandom);
      end else if (i == 1) begin
        check_val("sync_err_pulse", 32'(sync_err), 32'd0);
      end
      if (i == NPIX - 1) check_val("frame_done", 32'(frame_done), 32'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((exp_q.size() != 0 || m_valid) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int wx1, wy1, wx2, wy2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_s_ready", 32'(s_ready), 32'd1);
    check_val("rst_pulses", 32'({frame_done, cfg_err, sync_err}), 32'd0);
    check_val("rst_m_flags", 32'({m_sof, m_eol, m_eof}), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    base = n_out;
    drive_frame(2, 1, 4, 3, NPIX, 1'b0);
    drain();
    check_val("basic_count", 32'(n_out - base), 32'd9);

    rand_ready = 1'b1;
    gaps       = 1'b1;
    base = n_out;
    drive_frame(2, 1, 4, 3, NPIX, 1'b0);
    drain();
    check_val("bp_count", 32'(n_out - base), 32'd9);

    rand_ready = 1'b0;
    gaps       = 1'b0;
    @(posedge clk);
    #1;
    base = n_out;
    drive_frame(7, 5, 7, 5, NPIX, 1'b0);
    drain();
    check_val("1x1_count", 32'(n_out - base), 32'd1);

    base      = n_out;
    first_cyc = -1;
    drive_frame(0, 0, COLS - 1, ROWS - 1, NPIX, 1'b0);
    drain();
    check_val("full_count", 32'(n_out - base), 32'(NPIX));
    check_val("full_no_bubble", 32'(last_cyc - first_cyc), 32'(NPIX - 1));

    base = n_out;
    drive_frame(5, 0, 3, 2, NPIX, 1'b0);
    drain();
    check_val("invalid_count", 32'(n_out - base), 32'd0);
    check_val("cfg_err_sticky", 32'(cfg_err), 32'd1);
    drive_frame(1, 1, 2, 2, NPIX, 1'b0);
    drain();

    rand_ready = 1'b1;
    gaps       = 1'b1;
    drive_frame(1, 1, 6, 4, 20, 1'b0);
    drive_frame(0, 2, 7, 3, NPIX, 1'b1);
    drain();

    drive_frame(0, 0, COLS - 1, ROWS - 1, 13, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_mid_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    base = n_out;
    for (int i = 0; i < 10; i++) drive_beat(PW'($urandom), 1'b0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_discard", 32'(n_out - base), 32'd0);
    drive_frame(3, 0, 6, 5, NPIX, 1'b0);
    drain();

    for (int f = 0; f < 8; f++) begin
      wx1 = $urandom_range(0, COLS - 1);
      wy1 = $urandom_range(0, ROWS - 1);
      wx2 = $urandom_range(0, COLS + 1);
      wy2 = $urandom_range(0, ROWS + 1);
      drive_frame(wx1, wy1, wx2, wy2, NPIX, 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_crop_window.md
Name: stream_crop_window

Overview:
- Streaming, synthesisable successor to the file-based cropper.
- Accepts a raster-order multi-channel pixel stream over a valid/ready handshake and forwards only the pixels inside a runtime-programmable rectangular window, with sof/eol/eof framing regenerated for the cropped image.
- Sits between the image source (file reader or sensor front end) and downstream filter stages.
- Frame geometry is set by parameters; the window is programmable per frame.

Parameters:
- COLS, 512, input frame width in pixels
- ROWS, 512, input frame height in pixels
- CH, 1, channels per pixel (1 = grey, 3 = RGB)
- DW, 8, bits per channel
- XW, 10, coordinate width; must satisfy 2^XW >= max(COLS, ROWS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_x1  in  XW  window left column, inclusive
- cfg_y1  in  XW  window top row, inclusive
- cfg_x2  in  XW  window right column, inclusive
- cfg_y2  in  XW  window bottom row, inclusive
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  CH*DW  input pixel; channel 0 in the LSBs
- s_sof  in  1  marks the first pixel (0,0) of an input frame
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  CH*DW  cropped pixel
- m_sof  out  1  first pixel of the cropped frame
- m_eol  out  1  last pixel of a cropped row
- m_eof  out  1  last pixel of the cropped frame
- frame_done  out  1  one-cycle pulse after the last input pixel of a frame is accepted
- cfg_err  out  1  sticky until the next accepted s_sof; window latched for this frame is invalid
- sync_err  out  1  one-cycle pulse when s_sof arrives mid-frame

Behaviour:
- Reset: all outputs 0 except s_ready, which is 1. State IDLE; counters x = 0, y = 0.
- Input handshake and output register:
  - Input beat = s_valid && s_ready.
  - s_ready = !m_valid || m_ready. This is combinational from m_ready, and there is no dependence on s_valid.
  - The output is a single register stage: latency from input beat to m_valid is exactly 1 cycle.
  - While m_valid && !m_ready, m_data and all m_* flags hold stable.
- State machine:
  - IDLE:
    - Beats without s_sof are consumed and discarded.
    - A beat with s_sof latches cfg_* into internal window registers. That pixel is treated as (0,0), x advances to 1, and the state moves to ACTIVE.
  - ACTIVE:
    - Each beat advances x. At x == COLS-1, x wraps to 0 and y increments.
    - The beat at (COLS-1, ROWS-1) pulses frame_done on the next cycle and returns to IDLE.
    - s_sof while ACTIVE: pulse sync_err, discard the partial frame, and restart as if from IDLE with that pixel (cfg re-latched).
    - An in-flight output register is not flushed; it drains normally.
- Window test on each beat at (x,y): pass when x1 <= x <= x2 and y1 <= y <= y2, using the latched values. Pixels outside the window are consumed with no output.
- Output flags:
  - m_sof when (x,y) == (x1,y1).
  - m_eol when x == x2.
  - m_eof when (x,y) == (x2,y2).
  - A 1x1 window asserts all three on the same pixel.
- Config validity: the window is invalid if x1 > x2, y1 > y2, x2 >= COLS or y2 >= ROWS. When invalid:
  - set cfg_err at latch time;
  - emit no pixels for the frame;
  - still track counters and pulse frame_done.
- cfg_* changes during a frame have no effect until the next s_sof.
- Full-frame window (0,0)-(COLS-1,ROWS-1): a pure pass-through; with m_ready held high, 1 pixel per cycle with no bubbles.
- Reset mid-frame: state returns to IDLE, the output register is cleared (m_valid = 0), and all partial-frame data is lost.
- Counters compare with XW-bit unsigned arithmetic; no signed math.

Test Plan:
- Basic crop: COLS=8, ROWS=6, CH=1; pixel value = 8*y+x; window (2,1)-(4,3); m_ready=1.
  - Required: 9 outputs 10,11,12,18,19,20,26,27,28.
  - m_sof on 10; m_eol on 12, 20 and 28; m_eof on 28; frame_done one cycle after the 48th beat.
- Backpressure: same frame, m_ready toggled randomly 50%.
  - Required: identical output sequence.
  - m_data stable while m_valid && !m_ready.
  - s_ready low exactly when m_valid && !m_ready.
- Edge windows:
  - 1x1 at (7,5): single output 47 with sof, eol and eof all asserted.
  - Full frame (0,0)-(7,5): 48 outputs, 1 per cycle with no bubbles.
- Invalid config (5,0)-(3,2): zero outputs, cfg_err=1, frame_done still pulses. cfg_err clears on the next s_sof once a valid window is loaded.
- Resync and config timing:
  - s_sof injected at beat 20 of a frame: sync_err pulses and the new frame crops correctly from that pixel.
  - cfg changed mid-frame: no effect until the next s_sof.
- Reset and multi-channel:
  - rst asserted mid-frame: m_valid=0 and s_ready=1 on the next cycle; non-sof beats are discarded until s_sof.
  - CH=3, DW=8 with pixels 0xBBGGRR: channels pass through intact in order.
